cheri_rf_wport_arbiter: RTL and testbench
=========================================

// Module: cheri_rf_wport_arbiter
// PURPOSE
//  Shares the single register-file write port between the pipeline writeback (WB/LSU merged
//  write) and one background requester (e.g. register-clear / revocation sweep engine).
//  Pipeline writes always win. Background writes are held in a 1-entry buffer until a free slot.
//  Starvation escalates to a pipeline stall request. Sits between the writeback stage and ibex_register_file.
// PARAMETERS
//  StarveLimit  8      cycles a buffered bg write may wait before stall_pipe_o is raised (>=1)
//  CntWidth     4      width of wait counter; must hold StarveLimit
// PORTS
//  clk_i            in   1   clock
//  rst_ni           in   1   asynchronous active-low reset
//  pipe_we_i        in   1   pipeline write this cycle (WB result or LSU load data)
//  pipe_waddr_i     in   5   pipeline write address
//  pipe_wdata_i     in   32  pipeline write data
//  pipe_wcap_i      in   reg_cap_t  pipeline write capability metadata
//  bg_valid_i       in   1   background request valid
//  bg_ready_o       out  1   buffer empty, request accepted when valid&ready
//  bg_waddr_i       in   5   background address
//  bg_wdata_i       in   32  background data
//  bg_wcap_i        in   reg_cap_t  background capability
//  bg_done_o        out  1   pulse: buffered write committed (or dropped, see bg_superseded_o)
//  bg_superseded_o  out  1   pulse with bg_done_o: write discarded, newer pipeline write to same reg
//  stall_pipe_o     out  1   request ID/EX to withhold issue (LSU returns cannot be stalled)
//  rf_we_o          out  1   RF write enable
//  rf_waddr_o       out  5   RF write address
//  rf_wdata_o       out  32  RF write data
//  rf_wcap_o        out  reg_cap_t  RF write capability
//  starve_cnt_o     out  16  saturating count of cycles in FORCE (only with macro)
// BEHAVIOUR
//  Clock/reset: one clock clk_i; reset rst_ni is asynchronous, active-low.
//  Reset: state IDLE, buffer empty, counter 0. Outputs: bg_ready_o=1, all others 0,
//    rf_wcap_o=NULL_REG_CAP.
//  Write port is combinational. pipe_we_i=1: port = pipeline. Else if buffer full: port = buffer.
//    Else rf_we_o=0 and rf_wcap_o=NULL_REG_CAP.
//  FSM states: IDLE (empty), WAIT (full, counting), FORCE (full, stall_pipe_o=1).
//    IDLE->WAIT on accept; counter cleared.
//    WAIT: commit if !pipe_we_i -> IDLE. Else counter++. Reaching StarveLimit -> FORCE.
//    FORCE: commit on first cycle with !pipe_we_i -> IDLE. stall_pipe_o is Moore (from state).
//  Commit: bg_done_o pulses same cycle as rf_we_o. bg_ready_o=1 only in IDLE, so no accept in commit cycle.
//    The next request can be accepted in the following cycle.
//  Supersede: while buffer full, a pipe write with pipe_waddr_i==buffered addr clears the buffer.
//    bg_done_o=1 and bg_superseded_o=1 that cycle; next state IDLE. Newer data is never clobbered.
//  Address 0: accepted, then completes on its first cycle in WAIT with bg_done_o=1.
//    The rf_we_o path is not exercised for it.
//  The counter saturates at StarveLimit. Reset mid-wait discards the buffered write silently.
// CONFIGURATION
//  CHERI_WPORT_PERF_EN defined: 16-bit saturating starve_cnt_o counts cycles in FORCE.
//    Cleared only by reset.
//  Not defined: starve_cnt_o tied to 16'h0 and no counter flops are instantiated.
// STRUCTURE
//  reg_cap_t and NULL_REG_CAP come from cheri_pkg.
//  wport_state_e {IDLE,WAIT,FORCE} is added to cheri_pkg.
//  Single module, no sub-modules. The buffer is a plain flopped register set.
// TESTING
//  1 bg req addr 5 data 0x1234 with no pipe writes
//    -> accept cycle 0, rf_we_o addr 5 data 0x1234 in cycle 1 with bg_done_o.
//  2 bg req addr 7 while pipe writes addr 3 for 8 cycles (StarveLimit=8)
//    -> stall_pipe_o rises after 8 waits.
//    -> commit on first idle pipe cycle, then stall_pipe_o falls.
//  3 bg buffered addr 9, then pipe writes addr 9 data 0xAA
//    -> rf gets 0xAA, bg_done_o=1 and bg_superseded_o=1, no later write to reg 9.
//  4 bg req addr 0 -> bg_done_o next cycle, rf_we_o stays 0.
//  5 reset asserted while in FORCE
//    -> stall_pipe_o=0 and bg_ready_o=1 immediately, and no write after release.
//  6 with CHERI_WPORT_PERF_EN, hold FORCE for 5 cycles -> starve_cnt_o==5.
//    Without the macro it reads 0.

Source files
------------

// File: rtl/cheri_pkg.sv
// Shared CHERI register-file types and write-port arbiter state encoding.
package cheri_pkg;

    typedef struct packed {
        logic        valid;
        logic [3:0]  perms;
        logic [7:0]  otype;
        logic [17:0] bounds;
    } reg_cap_t;

    localparam reg_cap_t NULL_REG_CAP = '{
        valid:  1'b0,
        perms:  4'h0,
        otype:  8'hff,
        bounds: 18'h0
    };

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        FORCE
    } wport_state_e;

endpackage

// File: rtl/cheri_rf_wport_arbiter.sv
// RF write-port arbiter: pipeline wins, one buffered background write.
// Optional CHERI_WPORT_PERF_EN adds a saturating FORCE-cycle counter.
module cheri_rf_wport_arbiter
    import cheri_pkg::*;
#(
    parameter int unsigned StarveLimit = 8,
    parameter int unsigned CntWidth    = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        pipe_we_i,
    input  logic [4:0]  pipe_waddr_i,
    input  logic [31:0] pipe_wdata_i,
    input  reg_cap_t    pipe_wcap_i,
    input  logic        bg_valid_i,
    output logic        bg_ready_o,
    input  logic [4:0]  bg_waddr_i,
    input  logic [31:0] bg_wdata_i,
    input  reg_cap_t    bg_wcap_i,
    output logic        bg_done_o,
    output logic        bg_superseded_o,
    output logic        stall_pipe_o,
    output logic        rf_we_o,
    output logic [4:0]  rf_waddr_o,
    output logic [31:0] rf_wdata_o,
    output reg_cap_t    rf_wcap_o,
    output logic [15:0] starve_cnt_o
);

    wport_state_e        state_q, state_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic [4:0]          buf_addr_q;
    logic [31:0]         buf_data_q;
    reg_cap_t            buf_cap_q;
    logic                buf_commit;
    logic                accept;

    assign accept       = (state_q == IDLE) && bg_valid_i;
    assign bg_ready_o   = (state_q == IDLE);
    assign stall_pipe_o = (state_q == FORCE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            buf_addr_q <= '0;
            buf_data_q <= '0;
            buf_cap_q  <= NULL_REG_CAP;
        end else if (accept) begin
            buf_addr_q <= bg_waddr_i;
            buf_data_q <= bg_wdata_i;
            buf_cap_q  <= bg_wcap_i;
        end
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        bg_done_o       = 1'b0;
        bg_superseded_o = 1'b0;
        buf_commit      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bg_valid_i) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end
            end
            WAIT, FORCE: begin
                // x0 is hardwired, so a buffered write to it just retires
                if (buf_addr_q == 5'd0) begin
                    bg_done_o = 1'b1;
                    state_d   = IDLE;
                end else if (!pipe_we_i) begin
                    bg_done_o  = 1'b1;
                    buf_commit = 1'b1;
                    state_d    = IDLE;
                end else if (pipe_waddr_i == buf_addr_q) begin
                    bg_done_o       = 1'b1;
                    bg_superseded_o = 1'b1;
                    state_d         = IDLE;
                end else if (state_q == WAIT) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == CntWidth'(StarveLimit)) begin
                        state_d = FORCE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rf_we_o    = 1'b0;
        rf_waddr_o = '0;
        rf_wdata_o = '0;
        rf_wcap_o  = NULL_REG_CAP;
        if (pipe_we_i) begin
            rf_we_o    = 1'b1;
            rf_waddr_o = pipe_waddr_i;
            rf_wdata_o = pipe_wdata_i;
            rf_wcap_o  = pipe_wcap_i;
        end else if (buf_commit) begin
            rf_we_o    = 1'b1;
            rf_waddr_o = buf_addr_q;
            rf_wdata_o = buf_data_q;
            rf_wcap_o  = buf_cap_q;
        end
    end

`ifdef CHERI_WPORT_PERF_EN
    logic [15:0] perf_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_q <= '0;
        end else if (state_q == FORCE && perf_q != 16'hffff) begin
            perf_q <= perf_q + 16'd1;
        end
    end

    assign starve_cnt_o = perf_q;
`else
    assign starve_cnt_o = 16'h0;
`endif

endmodule

// File: tb/tb_cheri_rf_wport_arbiter.sv
// Randomised + directed bench for cheri_rf_wport_arbiter with a
// transaction-level model of the buffered background write.
module tb_cheri_rf_wport_arbiter;
    import cheri_pkg::*;

    localparam int LIM = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pipe_we_i = 1'b0;
    logic [4:0]  pipe_waddr_i = '0;
    logic [31:0] pipe_wdata_i = '0;
    reg_cap_t    pipe_wcap_i = NULL_REG_CAP;
    logic        bg_valid_i = 1'b0;
    logic [4:0]  bg_waddr_i = '0;
    logic [31:0] bg_wdata_i = '0;
    reg_cap_t    bg_wcap_i = NULL_REG_CAP;
    logic        bg_ready_o, bg_done_o, bg_superseded_o, stall_pipe_o;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    reg_cap_t    rf_wcap_o;
    logic [15:0] starve_cnt_o;

    cheri_rf_wport_arbiter #(.StarveLimit(LIM), .CntWidth(4)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .pipe_we_i(pipe_we_i), .pipe_waddr_i(pipe_waddr_i),
        .pipe_wdata_i(pipe_wdata_i), .pipe_wcap_i(pipe_wcap_i),
        .bg_valid_i(bg_valid_i), .bg_ready_o(bg_ready_o),
        .bg_waddr_i(bg_waddr_i), .bg_wdata_i(bg_wdata_i),
        .bg_wcap_i(bg_wcap_i), .bg_done_o(bg_done_o),
        .bg_superseded_o(bg_superseded_o), .stall_pipe_o(stall_pipe_o),
        .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o),
        .rf_wdata_o(rf_wdata_o), .rf_wcap_o(rf_wcap_o),
        .starve_cnt_o(starve_cnt_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // model: pending background write and how long it has been blocked
    bit          m_full = 0;
    logic [4:0]  m_addr = '0;
    logic [31:0] m_data = '0;
    reg_cap_t    m_cap = NULL_REG_CAP;
    int          m_waits = 0;
    int          m_force = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_starve();
`ifdef CHERI_WPORT_PERF_EN
        return m_force;
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        m_full = 0;
        m_waits = 0;
        m_force = 0;
    endtask

    task automatic model_check();
        bit          done, sup, we;
        logic [4:0]  a;
        logic [31:0] d;
        reg_cap_t    c;
        done = m_full && (m_addr == 0 || !pipe_we_i || pipe_waddr_i == m_addr);
        sup  = m_full && m_addr != 0 && pipe_we_i && pipe_waddr_i == m_addr;
        we = 0; a = '0; d = '0; c = NULL_REG_CAP;
        if (pipe_we_i) begin
            we = 1; a = pipe_waddr_i; d = pipe_wdata_i; c = pipe_wcap_i;
        end else if (m_full && m_addr != 0) begin
            we = 1; a = m_addr; d = m_data; c = m_cap;
        end
        chk("ready", bg_ready_o, !m_full);
        chk("stall", stall_pipe_o, m_full && m_waits >= LIM);
        chk("done", bg_done_o, done);
        chk("superseded", bg_superseded_o, sup);
        chk("rf_we", rf_we_o, we);
        chk("rf_waddr", rf_waddr_o, a);
        chk("rf_wdata", rf_wdata_o, d);
        chk("rf_wcap", rf_wcap_o, c);
        chk("starve_cnt", starve_cnt_o, exp_starve());
    endtask

    task automatic model_update();
        bit done;
        done = m_full && (m_addr == 0 || !pipe_we_i || pipe_waddr_i == m_addr);
        if (m_full && m_waits >= LIM && m_force < 65535) m_force++;
        if (done) begin
            m_full = 0;
        end else if (m_full) begin
            if (m_waits < LIM) m_waits++;
        end else if (bg_valid_i) begin
            m_full = 1;
            m_addr = bg_waddr_i;
            m_data = bg_wdata_i;
            m_cap = bg_wcap_i;
            m_waits = 0;
        end
    endtask

    task automatic drive(input bit pwe, input logic [4:0] pa,
                         input logic [31:0] pd, input bit bv,
                         input logic [4:0] ba, input logic [31:0] bd);
        logic [31:0] r1, r2;
        @(negedge clk);
        r1 = $urandom();
        r2 = $urandom();
        pipe_we_i = pwe;
        pipe_waddr_i = pa;
        pipe_wdata_i = pd;
        pipe_wcap_i = r1[30:0];
        bg_valid_i = bv;
        bg_waddr_i = ba;
        bg_wdata_i = bd;
        bg_wcap_i = r2[30:0];
        #1;
        model_check();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
    endtask

    task automatic cyc(input bit pwe, input logic [4:0] pa,
                       input logic [31:0] pd, input bit bv,
                       input logic [4:0] ba, input logic [31:0] bd);
        drive(pwe, pa, pd, bv, ba, bd);
        tick();
    endtask

    initial begin
        #12;
        chk("rst_ready", bg_ready_o, 1);
        chk("rst_stall", stall_pipe_o, 0);
        chk("rst_rf_we", rf_we_o, 0);
        chk("rst_done", bg_done_o, 0);
        chk("rst_wcap", rf_wcap_o, NULL_REG_CAP);
        chk("rst_starve", starve_cnt_o, 0);
        #3 rst_n = 1'b1;

        // 1: plain background write
        drive(0, 0, 0, 1, 5, 32'h1234);
        chk("t1_accept_ready", bg_ready_o, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("t1_we", rf_we_o, 1);
        chk("t1_addr", rf_waddr_o, 5);
        chk("t1_data", rf_wdata_o, 32'h1234);
        chk("t1_done", bg_done_o, 1);
        chk("t1_ready_busy", bg_ready_o, 0);
        tick();

        // 2: starvation escalates to stall
        cyc(0, 0, 0, 1, 7, 32'h77);
        for (int i = 0; i < LIM; i++) begin
            drive(1, 3, 32'h300 + i, 0, 0, 0);
            chk("t2_no_stall", stall_pipe_o, 0);
            tick();
        end
        drive(1, 3, 32'h3ff, 0, 0, 0);
        chk("t2_stall", stall_pipe_o, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("t2_commit_addr", rf_waddr_o, 7);
        chk("t2_commit_data", rf_wdata_o, 32'h77);
        chk("t2_commit_done", bg_done_o, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("t2_stall_fall", stall_pipe_o, 0);
        tick();

        // 3: supersede
        cyc(0, 0, 0, 1, 9, 32'h99);
        drive(1, 9, 32'hAA, 0, 0, 0);
        chk("t3_data", rf_wdata_o, 32'hAA);
        chk("t3_done", bg_done_o, 1);
        chk("t3_sup", bg_superseded_o, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("t3_no_late_we", rf_we_o, 0);
        tick();

        // 4: address 0
        cyc(0, 0, 0, 1, 0, 32'hdead);
        drive(0, 0, 0, 0, 0, 0);
        chk("t4_done", bg_done_o, 1);
        chk("t4_no_we", rf_we_o, 0);
        tick();

        // 5: reset while in FORCE
        cyc(0, 0, 0, 1, 7, 32'h55);
        for (int i = 0; i < LIM; i++) cyc(1, 3, i, 0, 0, 0);
        drive(1, 3, 32'h1, 0, 0, 0);
        chk("t5_in_force", stall_pipe_o, 1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_stall", stall_pipe_o, 0);
        chk("t5_rst_ready", bg_ready_o, 1);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        chk("t5_no_write", rf_we_o, 0);
        tick();

        // 6: perf counter over 5 FORCE cycles
        cyc(0, 0, 0, 1, 12, 32'hc);
        for (int i = 0; i < LIM + 5; i++) cyc(1, 3, i, 0, 0, 0);
        drive(1, 3, 32'h2, 0, 0, 0);
`ifdef CHERI_WPORT_PERF_EN
        chk("t6_starve", starve_cnt_o, 5);
`else
        chk("t6_starve", starve_cnt_o, 0);
`endif
        tick();
        cyc(0, 0, 0, 0, 0, 0);

        // random phase, with bursty pipeline load to reach FORCE
        for (int blk = 0; blk < 40; blk++) begin
            int busy;
            busy = (blk % 3 == 0) ? 95 : $urandom_range(10, 80);
            for (int i = 0; i < 25; i++) begin
                logic [31:0] r;
                r = $urandom();
                cyc($urandom_range(0, 99) < busy, 5'(r[2:0]), $urandom(),
                    r[8], 5'(r[13:11]), $urandom());
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
